seg_pattern_encoder: RTL and testbench



---
 rtl/seg_pattern_encoder_pkg.sv | 26 ++
 rtl/seg_pattern_encoder_if.sv | 30 +++
 rtl/seg_pattern_encoder_lookup.sv | 30 +++
 rtl/seg_pattern_encoder.sv | 127 ++++++++++++
 tb/tb_seg_pattern_encoder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pattern_encoder_pkg.sv
// +----------------------------------------------------------------------+
// | seg_enc_pkg: segment pattern / character code constants and types.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package seg_enc_pkg;

  typedef logic [2:0] code_t;

  // Active-low patterns, bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam code_t CODE_H     = 3'b000;
  localparam code_t CODE_E     = 3'b001;
  localparam code_t CODE_L     = 3'b010;
  localparam code_t CODE_O     = 3'b011;
  localparam code_t CODE_BLANK = 3'b111;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_encoder_if.sv
// +----------------------------------------------------------------------+
// | seg_pattern_encoder_if: sample input and result output handshakes.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface seg_pattern_encoder_if;
  import seg_enc_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_seg;
  logic       out_valid;
  logic       out_ready;
  code_t      out_code;
  logic       out_err;

  modport master (
    output in_valid, in_seg, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_seg, out_ready,
    output in_ready, out_valid, out_code, out_err
  );

endinterface

`default_nettype wire

// File: rtl/seg_pattern_encoder_lookup.sv
// +----------------------------------------------------------------------+
// | seg_lookup: combinational 7-segment pattern to character code.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_lookup
  import seg_enc_pkg::*;
(
  input  logic [6:0] seg_i,
  output code_t      code_o,
  output logic       err_o
);

  always_comb begin
    code_o = CODE_BLANK;
    err_o  = 1'b0;
    case (seg_i)
      SEG_H:     code_o = CODE_H;
      SEG_E:     code_o = CODE_E;
      SEG_L:     code_o = CODE_L;
      SEG_O:     code_o = CODE_O;
      SEG_BLANK: code_o = CODE_BLANK;
      default:   err_o  = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_pattern_encoder.sv
// +----------------------------------------------------------------------+
// | seg_pattern_encoder: stability-filtered 7-seg pattern to code, with  |
// | optional error counter under SEG_ENC_ERRCNT_EN. Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_pattern_encoder
  import seg_enc_pkg::*;
#(
  parameter int STABLE = 3,
  parameter int CNT_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY0,
  seg_pattern_encoder_if.slave bus_if
`ifdef SEG_ENC_ERRCNT_EN
  ,
  output logic [ERR_W-1:0]     err_count
`endif
);

  localparam logic [CNT_W-1:0] STABLE_C   = CNT_W'(STABLE);
  localparam bit               STABLE_ONE = (STABLE == 1);

  if (((2 ** CNT_W) <= STABLE) || (STABLE < 1) || (ERR_W < 1)) begin : g_param_check
    $error("seg_pattern_encoder: invalid STABLE/CNT_W/ERR_W");
  end

  logic [CNT_W-1:0] run_q, run_d;
  logic [6:0]       last_q, last_d;
  logic [6:0]       emit_q, emit_d;
  logic             emit_vld_q, emit_vld_d;
  logic             out_valid_q, out_valid_d;
  code_t            out_code_q, out_code_d;
  logic             out_err_q, out_err_d;

  code_t lk_code;
  logic  lk_err;
  logic  in_ready_w, accept, same, qualify;

  seg_lookup u_lookup (
    .seg_i  (bus_if.in_seg),
    .code_o (lk_code),
    .err_o  (lk_err)
  );

  assign in_ready_w = !out_valid_q || bus_if.out_ready;
  assign accept     = bus_if.in_valid && in_ready_w;
  assign same       = (bus_if.in_seg == last_q);

  always_comb begin
    run_d       = run_q;
    last_d      = last_q;
    emit_d      = emit_q;
    emit_vld_d  = emit_vld_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    qualify     = 1'b0;

    if (accept) begin
      if (same) begin
        run_d = (run_q >= STABLE_C) ? STABLE_C : run_q + 1'b1;
      end else begin
        run_d  = CNT_W'(1);
        last_d = bus_if.in_seg;
      end
      // Emit only on the transition into STABLE, never while a run sits saturated
      qualify = (run_d == STABLE_C)
             && ((run_q != STABLE_C) || !same || STABLE_ONE)
             && (!emit_vld_q || (bus_if.in_seg != emit_q));
    end

    if (qualify) begin
      out_valid_d = 1'b1;
      out_code_d  = lk_code;
      out_err_d   = lk_err;
      emit_d      = bus_if.in_seg;
      emit_vld_d  = 1'b1;
    end else if (bus_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      run_q       <= '0;
      last_q      <= SEG_BLANK;
      emit_q      <= SEG_BLANK;
      emit_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= CODE_BLANK;
      out_err_q   <= 1'b0;
    end else begin
      run_q       <= run_d;
      last_q      <= last_d;
      emit_q      <= emit_d;
      emit_vld_q  <= emit_vld_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus_if.in_ready  = in_ready_w;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_code  = out_code_q;
  assign bus_if.out_err   = out_err_q;

`ifdef SEG_ENC_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      err_cnt_q <= '0;
    end else if (qualify && lk_err && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_pattern_encoder.sv
// +----------------------------------------------------------------------+
// | tb_seg_pattern_encoder: directed self-checking bench for the encoder.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seg_pattern_encoder;
  import seg_enc_pkg::*;

  localparam logic [6:0] BAD = 7'b0110000;

  logic clk;
  logic key0;
  int   nt;
  int   nf;

  seg_pattern_encoder_if bus ();

`ifdef SEG_ENC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seg_pattern_encoder #(.STABLE(3), .CNT_W(4), .ERR_W(8)) dut (
    .CLOCK_50 (clk),
    .KEY0     (key0),
    .bus_if   (bus)
`ifdef SEG_ENC_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  logic [6:0] lk_seg;
  code_t      lk_code;
  logic       lk_err;

  seg_lookup u_ref (.seg_i(lk_seg), .code_o(lk_code), .err_o(lk_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [6:0] s);
    bus.in_valid = v;
    bus.in_seg   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key0 = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_seg = SEG_BLANK;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL rst_hold_valid: got %b want 0", bus.out_valid); end
    key0 = 1'b1;
    @(posedge clk); #1;
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    nt++; if (bus.out_code !== 3'b111) begin nf++; $display("FAIL rst_code: got %b want 111", bus.out_code); end
    nt++; if (bus.out_err !== 1'b0) begin nf++; $display("FAIL rst_err: got %b want 0", bus.out_err); end
    nt++; if (bus.in_ready !== 1'b1) begin nf++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
`ifdef SEG_ENC_ERRCNT_EN
    nt++; if (err_count !== 8'd0) begin nf++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
`endif
  endtask

  task automatic test_lookup();
    logic [6:0] pats [6];
    code_t      codes[6];
    logic       errs [6];
    pats = '{SEG_H, SEG_E, SEG_L, SEG_O, SEG_BLANK, BAD};
    codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b111};
    errs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      lk_seg = pats[i];
      #1;
      nt++;
      if ({lk_code, lk_err} !== {codes[i], errs[i]}) begin
        nf++;
        $display("FAIL lookup[%0d]: got code=%b err=%b want code=%b err=%b", i, lk_code, lk_err, codes[i], errs[i]);
      end
    end
  endtask

  task automatic test_qualify();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SEG_H);
      nt++;
      if (bus.out_valid !== (i == 2)) begin nf++; $display("FAIL qual_valid[%0d]: got %b want %b", i, bus.out_valid, (i == 2)); end
    end
    nt++; if (bus.out_code !== 3'b000) begin nf++; $display("FAIL qual_code: got %b want 000", bus.out_code); end
    nt++; if (bus.out_err !== 1'b0) begin nf++; $display("FAIL qual_err: got %b want 0", bus.out_err); end
    drive(1'b1, SEG_H);
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL qual_4th: got %b want 0", bus.out_valid); end
    drive(1'b0, SEG_H);
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL qual_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_sequence();
    logic [6:0] pats [5];
    logic       emits[5];
    code_t      codes[5];
    logic       exp_v;
    pats  = '{SEG_E, SEG_L, SEG_L, SEG_O, SEG_BLANK};
    emits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    codes = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b111};
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(k != 2, pats[r]);
        exp_v = emits[r] && (k == 3);
        nt++;
        if (bus.out_valid !== exp_v) begin nf++; $display("FAIL seq_valid[%0d.%0d]: got %b want %b", r, k, bus.out_valid, exp_v); end
        if (exp_v) begin
          nt++;
          if ({bus.out_code, bus.out_err} !== {codes[r], 1'b0}) begin
            nf++;
            $display("FAIL seq_code[%0d]: got %b/%b want %b/0", r, bus.out_code, bus.out_err, codes[r]);
          end
        end
      end
    end
  endtask

  task automatic test_glitch_error();
    logic [6:0] pats[6];
    pats = '{SEG_E, SEG_E, BAD, SEG_E, SEG_E, SEG_E};
    drive(1'b0, SEG_BLANK);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, pats[i]);
      nt++;
      if (bus.out_valid !== (i == 5)) begin nf++; $display("FAIL glitch_valid[%0d]: got %b want %b", i, bus.out_valid, (i == 5)); end
    end
    nt++; if (bus.out_code !== 3'b001) begin nf++; $display("FAIL glitch_code: got %b want 001", bus.out_code); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BAD);
      nt++;
      if (bus.out_valid !== (i == 2)) begin nf++; $display("FAIL err_valid[%0d]: got %b want %b", i, bus.out_valid, (i == 2)); end
    end
    nt++; if (bus.out_code !== 3'b111) begin nf++; $display("FAIL err_code: got %b want 111", bus.out_code); end
    nt++; if (bus.out_err !== 1'b1) begin nf++; $display("FAIL err_flag: got %b want 1", bus.out_err); end
`ifdef SEG_ENC_ERRCNT_EN
    nt++; if (err_count !== 8'd1) begin nf++; $display("FAIL err_count: got %0d want 1", err_count); end
`endif
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    drive(1'b0, SEG_BLANK);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, SEG_H);
    nt++; if (bus.out_valid !== 1'b1) begin nf++; $display("FAIL bp_emit: got %b want 1", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, SEG_O);
      nt++;
      if ({bus.in_ready, bus.out_valid, bus.out_code, bus.out_err} !== {1'b0, 1'b1, 3'b000, 1'b0}) begin
        nf++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b code=%b err=%b want rdy=0 v=1 code=000 err=0",
                 i, bus.in_ready, bus.out_valid, bus.out_code, bus.out_err);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SEG_O);
      nt++;
      if (bus.out_valid !== (i == 2)) begin nf++; $display("FAIL bp_release[%0d]: got %b want %b", i, bus.out_valid, (i == 2)); end
    end
    nt++; if (bus.out_code !== 3'b011) begin nf++; $display("FAIL bp_o_code: got %b want 011", bus.out_code); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    drive(1'b0, SEG_BLANK);
    for (int i = 0; i < 3; i++) drive(1'b1, SEG_H);
    drive(1'b1, SEG_O);
    drive(1'b1, SEG_O);
    nt++; if (bus.out_code !== 3'b000) begin nf++; $display("FAIL ar_pre_code: got %b want 000", bus.out_code); end
    bus.in_valid = 1'b0;
    #2;
    key0 = 1'b0;
    #1;
    nt++; if (bus.out_code !== 3'b111) begin nf++; $display("FAIL ar_code: got %b want 111", bus.out_code); end
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL ar_valid: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    key0 = 1'b1;
    drive(1'b1, SEG_O);
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL ar_one_o: got %b want 0", bus.out_valid); end
    drive(1'b1, SEG_BLANK);
    nt++; if (bus.out_valid !== 1'b0) begin nf++; $display("FAIL ar_blank: got %b want 0", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SEG_O);
      nt++;
      if (bus.out_valid !== (i == 2)) begin nf++; $display("FAIL ar_fresh[%0d]: got %b want %b", i, bus.out_valid, (i == 2)); end
    end
    nt++; if (bus.out_code !== 3'b011) begin nf++; $display("FAIL ar_o_code: got %b want 011", bus.out_code); end
  endtask

  initial begin
    nt = 0;
    nf = 0;
    lk_seg = SEG_BLANK;
    test_reset();
    test_lookup();
    test_qualify();
    test_sequence();
    test_glitch_error();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule

`default_nettype wire
